// File: rtl/fifo_stream_reader.sv
// Drains a fixed-latency fifo into a valid/ready stream. Reads are issued only when
// the local skid buffer has room for every word already requested.
module fifo_stream_reader #(
  parameter int DWIDTH       = 64,
  parameter int READ_LATENCY = 2,
  localparam int BUF_DEPTH   = READ_LATENCY + 2,
  localparam int LW          = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  input  logic              flush_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [LW-1:0]     level_o
);

  localparam int PW = $clog2(BUF_DEPTH);

  logic [READ_LATENCY-1:0] inflight_sr;
  logic [LW-1:0]           level;
  logic [LW-1:0]           inflight;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [DWIDTH-1:0]       mem [BUF_DEPTH];
  logic                    push;
  logic                    pop;
  logic                    credit;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + LW'(inflight_sr[i]);
    end
  end

  // Credit counts buffered plus requested words, so a return always finds a free slot.
  // The async reset also gates the request so it reads 0 while reset is held.
  always_comb begin
    credit       = ({1'b0, level} + {1'b0, inflight}) < (LW + 1)'(BUF_DEPTH);
    fifo_rdreq_o = !arst_i && !fifo_empty_i && !flush_i && credit;
    push         = inflight_sr[READ_LATENCY-1];
    valid_o      = (level != '0);
    pop          = valid_o && ready_i;
    data_o       = mem[rd_ptr];
    level_o      = level;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      inflight_sr <= '0;
    end else if (flush_i) begin
      inflight_sr <= '0;
    end else begin
      inflight_sr <= (inflight_sr << 1) | READ_LATENCY'(fifo_rdreq_o);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush_i) begin
      mem[wr_ptr] <= fifo_q_i;
    end
  end

  push_never_full: assert property (@(posedge clk_i) disable iff (arst_i)
    (push && !flush_i) |-> (level < LW'(BUF_DEPTH)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural fifo model, scoreboarded stream checks,
// table-driven streaming scenarios, flush/reset sequences and a latency sweep.
module tb_fifo_stream_reader;

  logic        clk;
  logic        arst;
  logic [63:0] fifo_q;
  logic        fifo_empty;
  logic        rdreq;
  logic        flush;
  logic [63:0] data;
  logic        valid;
  logic        ready;
  logic [2:0]  level;

  int unsigned n_pass;
  int unsigned n_total;

  logic [63:0] fmem [0:255];
  logic [7:0]  fwr;
  logic [7:0]  frd;
  logic [63:0] pipe [0:1];
  logic [63:0] sb [$];

  int unsigned delivered;
  int unsigned rdreq_cnt;
  int unsigned max_level;
  logic        stall_prev;
  logic [63:0] stall_data;
  logic        sw_rst;

  typedef struct {
    string       name;
    int unsigned nwords;
    int unsigned mode;
    int unsigned exp_rdreq;
    int unsigned exp_lat;
  } vec_t;

  vec_t vecs [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader #(.DWIDTH(64), .READ_LATENCY(2)) dut (
    .clk_i(clk), .arst_i(arst), .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty),
    .fifo_rdreq_o(rdreq), .flush_i(flush), .data_o(data), .valid_o(valid),
    .ready_i(ready), .level_o(level)
  );

  // Fifo model: registered output, two clocks from request to data.
  assign fifo_empty = (fwr == frd);
  assign fifo_q     = pipe[1];
  initial frd = '0;
  always @(posedge clk) begin
    if (rdreq) frd <= frd + 8'd1;
    pipe[0] <= rdreq ? fmem[frd] : 64'hBAD0_BAD0_BAD0_BAD0;
    pipe[1] <= pipe[0];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
    if (!arst) begin
      if (stall_prev) begin
        check("stall_data_hold", data, stall_data);
        check("stall_valid_hold", 64'(valid), 64'd1);
      end
      if (valid && ready) begin
        delivered++;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL extra_word: got %h expected no word at %0t", data, $time);
        end else begin
          check("stream_word", data, sb.pop_front());
        end
      end
      if (rdreq) rdreq_cnt++;
      if (32'(level) > max_level) max_level = 32'(level);
      stall_prev = valid && !ready && !flush;
      stall_data = data;
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] w);
    fmem[fwr] = w;
    fwr = fwr + 8'd1;
    sb.push_back(w);
  endtask

  task automatic wait_valid(output int unsigned n);
    n = 0;
    while (!valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int unsigned lat;
    int unsigned cyc;
    logic        all_done;

    vecs[0] = '{"stream",      100, 0, 100, 3};
    vecs[1] = '{"backpressure", 100, 1, 100, 3};
    vecs[2] = '{"runs_dry",      3, 0,   3, 3};

    n_pass = 0; n_total = 0;
    arst = 1'b1; flush = 1'b0; ready = 1'b0; fwr = '0;
    stall_prev = 1'b0; stall_data = '0;
    delivered = 0; rdreq_cnt = 0; max_level = 0;
    repeat (2) tick();
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_rdreq", 64'(rdreq), 64'd0);
    check("reset_level", 64'(level), 64'd0);
    check("reset_data",  data, 64'd0);

    foreach (vecs[v]) begin
      arst = 1'b1;
      fwr = frd;
      sb.delete();
      repeat (2) tick();
      for (int unsigned i = 0; i < vecs[v].nwords; i++)
        load({16'hF00D, 16'(v), 32'(i)});
      delivered = 0; rdreq_cnt = 0; max_level = 0;
      ready = (vecs[v].mode == 0);
      arst = 1'b0;
      wait_valid(lat);
      check({vecs[v].name, "_first_latency"}, 64'(lat), 64'(vecs[v].exp_lat));
      cyc = 0;
      while (delivered < vecs[v].nwords && cyc < 2000) begin
        if (vecs[v].mode == 1)
          ready = (cyc >= 10 && cyc < 30) ? 1'b0 : 1'($urandom_range(0, 1));
        tick();
        cyc++;
      end
      if (vecs[v].mode == 0)
        check({vecs[v].name, "_gapless_cycles"}, 64'(cyc), 64'(vecs[v].nwords));
      ready = 1'b1;
      repeat (6) tick();
      check({vecs[v].name, "_delivered"}, 64'(delivered), 64'(vecs[v].nwords));
      check({vecs[v].name, "_rdreq_pulses"}, 64'(rdreq_cnt), 64'(vecs[v].exp_rdreq));
      check({vecs[v].name, "_sb_empty"}, 64'(sb.size()), 64'd0);
      check({vecs[v].name, "_max_level_le_4"}, 64'(max_level <= 4), 64'd1);
      check({vecs[v].name, "_idle_valid"}, 64'(valid), 64'd0);
    end

    // Dry fifo refilled with a fourth word.
    load(64'h0000_0004_0000_0004);
    wait_valid(lat);
    check("refill_latency", 64'(lat), 64'd3);
    tick();
    check("refill_delivered", 64'(delivered), 64'd4);
    check("refill_rdreq", 64'(rdreq_cnt), 64'd4);

    // Flush with two words buffered and two returning.
    ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) load(64'hF1F1_0000_0000_0000 | 64'(i));
    repeat (4) tick();
    check("preflush_level", 64'(level), 64'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", 64'(valid), 64'd0);
    check("flush_level", 64'(level), 64'd0);
    sb.delete();
    ready = 1'b1;
    repeat (6) tick();
    check("late_returns_dropped_valid", 64'(valid), 64'd0);
    check("late_returns_dropped_level", 64'(level), 64'd0);
    flush = 1'b1;
    load(64'h0000_0000_0000_00A5);
    #1;
    check("flush_blocks_rdreq", 64'(rdreq), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("rdreq_resumes", 64'(rdreq), 64'd1);
    wait_valid(lat);
    check("post_flush_latency", 64'(lat), 64'd3);
    check("post_flush_first_word", data, 64'h0000_0000_0000_00A5);
    tick();
    check("post_flush_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset mid-clock with a full buffer and words left in the fifo.
    ready = 1'b0;
    for (int unsigned i = 0; i < 6; i++) load(64'hE0E0_0000_0000_0000 | 64'(i));
    repeat (8) tick();
    check("prereset_level", 64'(level), 64'd4);
    check("prereset_valid", 64'(valid), 64'd1);
    #2;
    arst = 1'b1;
    #1;
    check("async_reset_valid", 64'(valid), 64'd0);
    check("async_reset_rdreq", 64'(rdreq), 64'd0);
    check("async_reset_level", 64'(level), 64'd0);
    check("async_reset_data",  data, 64'd0);
    fwr = frd;
    sb.delete();
    repeat (2) tick();
    arst = 1'b0;
    repeat (6) tick();
    check("post_reset_idle_valid", 64'(valid), 64'd0);

    cyc = 0;
    all_done = sw[0].done && sw[1].done && sw[2].done;
    while (!all_done && cyc < 1000) begin
      tick();
      cyc++;
      all_done = sw[0].done && sw[1].done && sw[2].done;
    end
    check("sweep_done", 64'(all_done), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    sw_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sw_rst = 1'b0;
  end

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int L  = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    localparam int LW = $clog2(L + 3);

    logic [63:0]   q;
    logic [63:0]   d;
    logic          rq;
    logic          v;
    logic [LW-1:0] lv;
    logic [63:0]   p [0:3];
    logic [7:0]    rd;
    logic          empty;
    logic          done;

    assign empty = (rd == 8'd100);
    assign q     = p[L-1];

    always @(posedge clk or posedge sw_rst) begin
      if (sw_rst) rd <= '0;
      else if (rq) rd <= rd + 8'd1;
    end

    always @(posedge clk) begin
      p[0] <= rq ? {32'(L), 24'h0, rd} : 64'hBAD1_BAD1_BAD1_BAD1;
      for (int k = 1; k < 4; k++) p[k] <= p[k-1];
    end

    fifo_stream_reader #(.DWIDTH(64), .READ_LATENCY(L)) dut (
      .clk_i(clk), .arst_i(sw_rst), .fifo_q_i(q), .fifo_empty_i(empty),
      .fifo_rdreq_o(rq), .flush_i(1'b0), .data_o(d), .valid_o(v),
      .ready_i(1'b1), .level_o(lv)
    );

    initial begin
      int unsigned n;
      done = 1'b0;
      @(negedge sw_rst);
      n = 0;
      while (!v && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check($sformatf("sweep_L%0d_latency", L), 64'(n), 64'(L + 1));
      for (int unsigned i = 0; i < 100; i++) begin
        @(negedge clk);
        check($sformatf("sweep_L%0d_valid_%0d", L, i), 64'(v), 64'd1);
        check($sformatf("sweep_L%0d_word_%0d", L, i), d, {32'(L), 24'h0, 8'(i)});
      end
      repeat (3) @(negedge clk);
      check($sformatf("sweep_L%0d_reads", L), 64'(rd), 64'd100);
      check($sformatf("sweep_L%0d_drained", L), 64'(v), 64'd0);
      check($sformatf("sweep_L%0d_level", L), 64'(lv), 64'd0);
      done = 1'b1;
    end
  end

endmodule
